// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative multiplier (and the divider that reuses abs_val).
package mult_pkg;

    localparam int unsigned MULT_WIDTH   = 32;
    localparam int unsigned MULT_LATENCY = MULT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    // Magnitude of a width-bit operand held zero-extended in 64 bits.
    // The most-negative value maps to 2^(width-1), which still fits unsigned.
    function automatic logic [63:0] abs_val(input logic [63:0] value,
                                            input logic        is_signed,
                                            input int unsigned width);
        logic [63:0] mask;
        logic [5:0]  sidx;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        sidx = 6'(width - 1);
        if (is_signed && value[sidx])
            return (~value + 64'd1) & mask;
        return value & mask;
    endfunction

endpackage

// File: rtl/mult_unit_if.sv
// Request/response bundle between the EX stage and the multiplier.
interface mult_unit_if #(parameter int unsigned WIDTH = 32);
    logic               start;
    logic               is_signed;
    logic [0:WIDTH-1]   op_a;
    logic [0:WIDTH-1]   op_b;
    logic               flush;
    logic               mul_stall;
    logic               done;
    logic [WIDTH-1:0]   product_hi;
    logic [WIDTH-1:0]   product_lo;

    modport master (
        output start, is_signed, op_a, op_b, flush,
        input  mul_stall, done, product_hi, product_lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b, flush,
        output mul_stall, done, product_hi, product_lo
    );
endinterface

// File: rtl/mult_unit.sv
// Shift-add multiplier: one partial product per cycle on magnitudes, sign fixed up at the end.
// Operands arrive with bit 0 as the MSB, so op_a[0]/op_b[0] are the sign bits.
module mult_unit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    mult_unit_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    mult_state_t        state_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic               neg_q;
    logic               done_q;
    logic [WIDTH-1:0]   prod_hi_q;
    logic [WIDTH-1:0]   prod_lo_q;

    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] full_d;
    logic [2*WIDTH-1:0] result_d;

    always_comb begin
        mag_a_d  = WIDTH'(abs_val(64'(bus.op_a), bus.is_signed, WIDTH));
        mag_b_d  = WIDTH'(abs_val(64'(bus.op_b), bus.is_signed, WIDTH));
        sum_d    = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
        // {carry, acc, multiplier} shifted right by one
        full_d   = {sum_d, mplier_q[WIDTH-1:1]};
        result_d = neg_q ? -full_d : full_d;
    end

    // Combinational so the requesting instruction freezes in EX the same cycle.
    assign bus.mul_stall  = !bus.flush && (bus.start || (state_q == RUN));
    assign bus.done       = done_q;
    assign bus.product_hi = prod_hi_q;
    assign bus.product_lo = prod_lo_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        mcand_q  <= mag_a_d;
                        mplier_q <= mag_b_d;
                        neg_q    <= bus.is_signed & (bus.op_a[0] ^ bus.op_b[0]);
                        acc_q    <= '0;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= sum_d[WIDTH:1];
                    mplier_q <= {sum_d[0], mplier_q[WIDTH-1:1]};
                    count_q  <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        prod_hi_q <= result_d[2*WIDTH-1:WIDTH];
                        prod_lo_q <= result_d[WIDTH-1:0];
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench: stimulus pushes reference products, a negedge monitor pops on done.
module tb_mult_unit;
    import mult_pkg::*;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [63:0] last_prod = 64'd0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mult_unit_if #(.WIDTH(32)) bus();

    mult_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) return longint'($signed(a)) * longint'($signed(b));
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Monitor: every done must match the oldest outstanding request, on its due cycle.
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check64("product", {bus.product_hi, bus.product_lo}, mon_e.prod);
                check64("done_cycle", 64'(cyc), 64'(mon_e.due));
                last_prod = mon_e.prod;
                $display("txn done cycle=%0d product=%h", cyc, {bus.product_hi, bus.product_lo});
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        e.prod = ref_mul(a, b, s);
        e.due  = cyc + MULT_LATENCY;
        sb.push_back(e);
        $display("txn issue a=%h b=%h signed=%0d expect=%h", a, b, s, e.prod);
    endtask

    task automatic wait_done(inout int stalls, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (bus.mul_stall) stalls++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic mul_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        int stalls;
        bit seen;
        stalls = 0;
        @(posedge clock); #1;
        issue(a, b, s);
        @(negedge clock);
        if (bus.mul_stall) stalls++;
        @(posedge clock); #1;
        bus.start = 1'b0;
        wait_done(stalls, seen);
        check64("done_seen", 64'(seen), 64'd1);
        check64("stall_cycles", 64'(stalls), 64'(MULT_LATENCY));
    endtask

    logic [31:0] dir_a [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h00000000};
    logic [31:0] dir_b [6] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h80000000, 32'h00000001, 32'h80000000};
    logic        dir_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    initial begin
        int  stalls;
        bit  seen;
        logic [31:0] ra, rb;

        reset = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.is_signed = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check64("reset_done", 64'(bus.done), 64'd0);
        check64("reset_stall", 64'(bus.mul_stall), 64'd0);
        check64("reset_product", {bus.product_hi, bus.product_lo}, 64'd0);

        for (int i = 0; i < 6; i++) mul_op(dir_a[i], dir_b[i], dir_s[i]);

        // Back-to-back with ignored start pulses during RUN.
        @(posedge clock); #1 issue(32'd7, 32'd6, 1'b0);
        @(posedge clock); #1 bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            bus.op_a = $urandom; bus.op_b = $urandom; bus.start = 1'b1;
            @(posedge clock); #1 bus.start = 1'b0;
        end
        stalls = 0;
        wait_done(stalls, seen);
        check64("b2b_first_seen", 64'(seen), 64'd1);
        issue(32'd3, 32'd5, 1'b0);
        #1 check64("b2b_done_stall", 64'(bus.mul_stall), 64'd1);
        @(posedge clock); #1 bus.start = 1'b0;
        stalls = 0;
        wait_done(stalls, seen);
        check64("b2b_second_seen", 64'(seen), 64'd1);

        // Flush mid-run.
        @(posedge clock); #1 issue(32'd9, 32'd9, 1'b0);
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #1 bus.flush = 1'b1;
        void'(sb.pop_back());
        #1 check64("flush_stall", 64'(bus.mul_stall), 64'd0);
        @(posedge clock); #1 bus.flush = 1'b0;
        @(negedge clock);
        check64("post_flush_stall", 64'(bus.mul_stall), 64'd0);
        check64("post_flush_done", 64'(bus.done), 64'd0);
        check64("post_flush_hold", {bus.product_hi, bus.product_lo}, last_prod);
        repeat (40) @(negedge clock);
        check64("flush_hold_late", {bus.product_hi, bus.product_lo}, last_prod);

        // Start coinciding with flush is dropped.
        @(posedge clock); #1 issue(32'd2, 32'd2, 1'b0);
        bus.flush = 1'b1;
        void'(sb.pop_back());
        @(posedge clock); #1 bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clock);
        check64("flush_start_dropped", 64'(bus.mul_stall), 64'd0);
        mul_op(32'd12345, 32'd678, 1'b0);

        // Reset mid-run.
        @(posedge clock); #1 issue(32'hDEADBEEF, 32'h12345678, 1'b1);
        @(posedge clock); #1 bus.start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check64("mid_reset_done", 64'(bus.done), 64'd0);
        check64("mid_reset_stall", 64'(bus.mul_stall), 64'd0);
        check64("mid_reset_product", {bus.product_hi, bus.product_lo}, 64'd0);
        last_prod = 64'd0;
        mul_op(32'hFFFFFFF9, 32'd6, 1'b1);

        // Randomized operands, with corner values mixed in.
        for (int i = 0; i < 20; i++) begin
            ra = (i % 4 == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb = (i % 5 == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            mul_op(ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clock);
        check64("outstanding", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative shift-add 32x32 → 64-bit integer multiplier for the EX stage, instantiated beside the ALU/FPU. It accepts one multiply per request, produces the full signed or unsigned product after a fixed multi-cycle latency, and drives `mul_stall`, the stall that freezes IF/ID/EX while a multiply is in flight. The pipeline consumes `product_lo` and `product_hi` in the cycle `done` is high.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. The product is `2*WIDTH`. The iteration count equals `WIDTH`.

Ports:
- `clock`  in  1  system clock. Single clock domain; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a multiply using `op_a`, `op_b` and `is_signed` sampled this cycle.
- `is_signed`  in  1  1 = two's-complement operands; 0 = unsigned operands.
- `op_a`  in  WIDTH  multiplicand. Bit 0 is the MSB.
- `op_b`  in  WIDTH  multiplier. Bit 0 is the MSB.
- `flush`  in  1  abort any in-flight multiply (branch/jump squash).
- `mul_stall`  out  1  pipeline freeze request.
- `done`  out  1  one-cycle pulse; the product is valid.
- `product_hi`  out  WIDTH  upper half of the product.
- `product_lo`  out  WIDTH  lower half of the product.

## Operation

States: IDLE, RUN, DONE.

- **IDLE**
  - `start=1` latches `|op_a|` and `|op_b|` (absolute values only when `is_signed=1`).
  - Latches `neg = is_signed & (op_a[0] ^ op_b[0])`.
  - Clears the accumulator and sets `count=0`, then goes to RUN.
- **RUN**
  - Each cycle: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half.
  - Then shift the {carry, accumulator, multiplier} right by 1 and increment `count`.
  - When `count==WIDTH-1`, do the final iteration and go to DONE.
  - On that final edge, the result registers load the accumulator, negated when `neg=1`.
- **DONE**
  - `done=1`.
  - `start=1` is accepted exactly as in IDLE (back-to-back multiplies); otherwise go to IDLE.
- **`mul_stall`** = `(state==IDLE|DONE) & start` OR `state==RUN`.
  - It is combinational, so the requesting instruction is frozen in EX in the same cycle.
- **Width rule:** magnitudes are WIDTH-bit unsigned, so the most-negative value (magnitude 2^(WIDTH-1)) needs no extra bit. The accumulator carries one extra carry bit.
- **`start` during RUN:** ignored.
- **`flush`:** highest priority after reset.
  - From any state, go to IDLE on the next edge.
  - `done` stays 0 and `product_*` keep their previous value.
  - `mul_stall` is forced to 0 in the flush cycle.
  - A `start` in the same cycle as `flush` is dropped.
- **`reset`:** from any state, including mid-RUN, sets state=IDLE, `count=0`, `done=0`, `mul_stall=0`, `product_hi=0`, `product_lo=0`.

## Timing

- Cycle 0: `start` is sampled and `mul_stall=1`.
- Cycles 1..WIDTH: RUN with `mul_stall=1`.
- Cycle WIDTH+1: DONE, `done=1`, `mul_stall=0`, product valid.
- Total stall is WIDTH+1 cycles (33 at default).
- `product_*` are registered and hold until the next completed multiply or reset.
- `done` is high for exactly one cycle per completed multiply.
- Back-to-back: a `start` in DONE cycle N gives the next `done` at N+WIDTH+1.
- No combinational path from `op_a`/`op_b` to any output. `mul_stall` depends combinationally only on `start`, `flush` and state.

## Structure

- Shared package `mult_pkg`:
  - `mult_state_t` enum {IDLE, RUN, DONE}.
  - `MULT_LATENCY = WIDTH+1`.
  - Function `abs_val(value, is_signed)` shared with divider work.
- One module. The counter and datapath stay inline; no sub-module is warranted.

## Test plan

- Unsigned: `op_a=0xFFFFFFFF`, `op_b=0xFFFFFFFF`, `is_signed=0` -> at cycle 33, `product_hi=0xFFFFFFFE`, `product_lo=0x00000001`, `done=1` for 1 cycle; `mul_stall` high for cycles 0-32 exactly.
- Signed mixed: `op_a=0xFFFFFFFF` (-1), `op_b=0x00000001`, `is_signed=1` -> `product_hi=0xFFFFFFFF`, `product_lo=0xFFFFFFFF`. The same operands with `is_signed=0` -> `product_hi=0`, `product_lo=0xFFFFFFFF`.
- Most-negative squared: `0x80000000 * 0x80000000`, `is_signed=1` -> `product_hi=0x40000000`, `product_lo=0`. Also `0x80000000 * 0x00000001` signed -> `0xFFFFFFFF_80000000`.
- Back-to-back: `7*6` completes, then `start` in the DONE cycle with `3*5` -> the first `done` shows 42; the second `done` shows 15 exactly 33 cycles later. `start` pulses during RUN are ignored.
- Flush mid-run: start `9*9`, assert `flush` at cycle 10 -> next cycle IDLE, `mul_stall=0`, no `done`, `product_*` still hold the prior result. A new `start` then completes normally.
- Reset mid-run: start a multiply, assert `reset` at cycle 5 -> next cycle all outputs 0, state IDLE. A `start` after reset completes with the correct product.
